// File: rtl/inst_fetch_if.sv
// Bundle between the IF stage, stall control, EX redirect, the memory
// controller byte port and the IF/ID register.
//
// Handshakes:
//  - Memory port: mem_req is a level held for a whole 4-byte fetch, and
//    mem_addr names the byte wanted. The controller answers with a one-cycle
//    mem_valid strobe carrying that byte on mem_byte. A strobe while mem_req
//    is low is stale and gets dropped.
//  - Output slot: if_flag marks if_pc/if_inst as valid. The IF/ID register
//    takes the slot on any edge where stall[0] is low. While stall[0] is high
//    the slot, if full, is frozen.
interface inst_fetch_if;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [7:0]  mem_byte;
  logic        if_flag;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [2:0]  dbg_state;

  modport master (
    input  stall, branch_flag, branch_target, mem_valid, mem_byte,
    output mem_req, mem_addr, if_flag, if_pc, if_inst, dbg_state
  );

  modport slave (
    output stall, branch_flag, branch_target, mem_valid, mem_byte,
    input  mem_req, mem_addr, if_flag, if_pc, if_inst, dbg_state
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage.
// Holds the PC and looks it up in a direct-mapped instruction cache. A hit
// presents the word in the same cycle. A miss reads the word as four bytes
// from the memory controller, assembles it little-endian and writes the line.
// A taken branch from EX redirects the PC and abandons any fetch in progress.
// dbg_state exposes the FSM encoding.
module inst_fetch #(
  parameter int INDEX_W = 7
) (
  input  logic       clk,
  input  logic       rst,
  inst_fetch_if.master bus
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  // IDLE: lookup; Bk: waiting for byte k of a miss.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_B0   = 3'd1,
    S_B1   = 3'd2,
    S_B2   = 3'd3,
    S_B3   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [23:0] buf_q, buf_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        if_flag_q, if_flag_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               stop;
  logic               slot_free;
  logic               cache_we;
  logic [31:0]        fill_word;
  logic               unused_stall;

  assign idx       = pc_q[INDEX_W+1:2];
  assign tag       = pc_q[31:INDEX_W+2];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign stop      = bus.stall[0];
  // The slot is free when empty or being taken by IF/ID on this edge.
  assign slot_free = !if_flag_q || !stop;
  assign fill_word = {bus.mem_byte, buf_q};

  // Only stall[0] concerns this stage.
  assign unused_stall = ^bus.stall[5:1];

  // Next-state logic: branch beats fill progress, which beats a new lookup.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if_flag_d  = if_flag_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    cache_we   = 1'b0;

    // An instruction taken by IF/ID leaves an empty slot unless refilled below.
    if (slot_free) begin
      if_flag_d = 1'b0;
      if_pc_d   = '0;
      if_inst_d = '0;
    end

    if (bus.branch_flag) begin
      pc_d      = bus.branch_target;
      state_d   = S_IDLE;
      mem_req_d = 1'b0;
      buf_d     = '0;
      if_flag_d = 1'b0;
      if_pc_d   = '0;
      if_inst_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (slot_free) begin
            if (hit) begin
              if_flag_d = 1'b1;
              if_pc_d   = pc_q;
              if_inst_d = data_q[idx];
              pc_d      = pc_q + 32'd4;
            end else begin
              mem_req_d  = 1'b1;
              mem_addr_d = pc_q;
              state_d    = S_B0;
            end
          end
        end
        S_B0: begin
          if (bus.mem_valid) begin
            buf_d[7:0] = bus.mem_byte;
            mem_addr_d = pc_q + 32'd1;
            state_d    = S_B1;
          end
        end
        S_B1: begin
          if (bus.mem_valid) begin
            buf_d[15:8] = bus.mem_byte;
            mem_addr_d  = pc_q + 32'd2;
            state_d     = S_B2;
          end
        end
        S_B2: begin
          if (bus.mem_valid) begin
            buf_d[23:16] = bus.mem_byte;
            mem_addr_d   = pc_q + 32'd3;
            state_d      = S_B3;
          end
        end
        S_B3: begin
          // A fill only starts with the slot free, so nothing unconsumed is lost.
          if (bus.mem_valid) begin
            cache_we  = 1'b1;
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
            if_flag_d = 1'b1;
            if_pc_d   = pc_q;
            if_inst_d = fill_word;
            pc_d      = pc_q + 32'd4;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, PC, byte buffer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      buf_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      if_flag_q  <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      if_flag_q  <= if_flag_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  // Valid bits clear on reset, so a reset during a fill leaves the line invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (cache_we) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data storage needs no reset; it is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (cache_we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= fill_word;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.if_flag   = if_flag_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a byte memory, a cache/PC reference model and
// directed plus randomized scenarios.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst;

  inst_fetch_if bus ();

  inst_fetch #(.INDEX_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a PC, a direct-mapped tag table and the expected fill addresses.
  logic [31:0] model_pc;
  bit          m_val [128];
  logic [31:0] m_tag [128];
  logic [31:0] exp_q [$];
  logic [7:0]  mem_a [logic [31:0]];

  int resp_pct = 50;
  bit spur_en  = 1'b0;
  bit pres_evt;

  bit          p_rst, p_branch, p_req, p_valid, p_flag, p_stall;
  logic [31:0] p_target, p_addr, p_pc, p_inst;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (!mem_a.exists(a)) mem_a[a] = 8'($urandom);
    return mem_a[a];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {mem_rd(pc + 32'd3), mem_rd(pc + 32'd2), mem_rd(pc + 32'd1), mem_rd(pc)};
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) % 128);
    return m_val[i] && (m_tag[i] == (pc >> 9));
  endfunction

  function automatic void model_fill(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) % 128);
    m_val[i] = 1'b1;
    m_tag[i] = pc >> 9;
  endfunction

  function automatic void model_reset();
    model_pc = '0;
    for (int i = 0; i < 128; i++) m_val[i] = 1'b0;
    exp_q.delete();
  endfunction

  // One clock: capture what the DUT sees, step, score the result, drive memory.
  task automatic tick();
    p_rst    = rst;
    p_branch = bus.branch_flag;
    p_target = bus.branch_target;
    p_req    = bus.mem_req;
    p_addr   = bus.mem_addr;
    p_valid  = bus.mem_valid;
    p_flag   = bus.if_flag;
    p_stall  = bus.stall[0];
    p_pc     = bus.if_pc;
    p_inst   = bus.if_inst;
    @(posedge clk);
    #1;
    bus.branch_flag = 1'b0;
    pres_evt = 1'b0;
    if (p_rst || rst) begin
      // nothing to score while reset is applied
    end else if (p_branch) begin
      n_cmp++;
      if (bus.if_flag !== 1'b0 || bus.mem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL sb_branch: if_flag=%b mem_req=%b, want 0 0", bus.if_flag, bus.mem_req);
      end
      model_pc = p_target;
      exp_q.delete();
    end else if (p_req) begin
      if (p_valid) begin
        n_cmp++;
        if (exp_q.size() == 0 || p_addr !== exp_q[0]) begin
          n_bad++;
          $display("FAIL sb_fill_addr: mem_addr=%h, want %h", p_addr,
                   (exp_q.size() != 0) ? exp_q[0] : 32'hxxxxxxxx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          n_cmp++;
          if (bus.mem_req !== 1'b0 || bus.if_flag !== 1'b1 || bus.if_pc !== model_pc ||
              bus.if_inst !== word_at(model_pc)) begin
            n_bad++;
            $display("FAIL sb_fill_done: req=%b flag=%b pc=%h inst=%h, want 0 1 %h %h",
                     bus.mem_req, bus.if_flag, bus.if_pc, bus.if_inst, model_pc, word_at(model_pc));
          end
          model_fill(model_pc);
          model_pc = model_pc + 32'd4;
          pres_evt = 1'b1;
        end else begin
          n_cmp++;
          if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_q[0] || bus.if_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL sb_fill_step: req=%b addr=%h flag=%b, want 1 %h 0",
                     bus.mem_req, bus.mem_addr, bus.if_flag, exp_q[0]);
          end
        end
      end else begin
        n_cmp++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== p_addr || bus.if_flag !== 1'b0) begin
          n_bad++;
          $display("FAIL sb_fill_wait: req=%b addr=%h flag=%b, want 1 %h 0",
                   bus.mem_req, bus.mem_addr, bus.if_flag, p_addr);
        end
      end
    end else if (p_flag && p_stall) begin
      n_cmp++;
      if (bus.if_flag !== 1'b1 || bus.if_pc !== p_pc || bus.if_inst !== p_inst || bus.mem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL sb_hold: flag=%b pc=%h inst=%h req=%b, want 1 %h %h 0",
                 bus.if_flag, bus.if_pc, bus.if_inst, bus.mem_req, p_pc, p_inst);
      end
    end else if (model_hit(model_pc)) begin
      n_cmp++;
      if (bus.if_flag !== 1'b1 || bus.if_pc !== model_pc || bus.if_inst !== word_at(model_pc) ||
          bus.mem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL sb_hit: flag=%b pc=%h inst=%h req=%b, want 1 %h %h 0",
                 bus.if_flag, bus.if_pc, bus.if_inst, bus.mem_req, model_pc, word_at(model_pc));
      end
      model_pc = model_pc + 32'd4;
      pres_evt = 1'b1;
    end else begin
      n_cmp++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== model_pc || bus.if_flag !== 1'b0) begin
        n_bad++;
        $display("FAIL sb_miss_start: req=%b addr=%h flag=%b, want 1 %h 0",
                 bus.mem_req, bus.mem_addr, bus.if_flag, model_pc);
      end
      for (int k = 0; k < 4; k++) exp_q.push_back(model_pc + 32'(k));
    end
    // Memory controller: random latency, optional stale strobes while idle.
    if (!rst && bus.mem_req && ($urandom_range(0, 99) < resp_pct)) begin
      bus.mem_valid = 1'b1;
      bus.mem_byte  = mem_rd(bus.mem_addr);
    end else if (!rst && !bus.mem_req && spur_en && ($urandom_range(0, 9) == 0)) begin
      bus.mem_valid = 1'b1;
      bus.mem_byte  = 8'($urandom);
    end else begin
      bus.mem_valid = 1'b0;
      bus.mem_byte  = 8'h00;
    end
  endtask

  task automatic wait_pres(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (pres_evt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (bus.dbg_state == st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_branch(input logic [31:0] tgt);
    bus.branch_flag   = 1'b1;
    bus.branch_target = tgt;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = '0;
    bus.branch_flag = 1'b0;
    bus.branch_target = '0;
    bus.mem_valid = 1'b0;
    bus.mem_byte = '0;
    model_reset();
    #2;
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.if_flag !== 1'b0 ||
        bus.if_pc !== 32'h0 || bus.if_inst !== 32'h0 || bus.dbg_state !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_values: req=%b addr=%h flag=%b pc=%h inst=%h st=%0d, want all 0",
               bus.mem_req, bus.mem_addr, bus.if_flag, bus.if_pc, bus.if_inst, bus.dbg_state);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_first_fill();
    bit ok;
    wait_pres(100, ok);
    n_cmp++;
    if (!ok || bus.if_pc !== 32'h0 || bus.if_inst !== 32'h00000013) begin
      n_bad++;
      $display("FAIL first_fill: ok=%b pc=%h inst=%h, want 1 00000000 00000013", ok, bus.if_pc, bus.if_inst);
    end
    tick();
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4) begin
      n_bad++;
      $display("FAIL pc_after_fill: req=%b addr=%h, want 1 00000004", bus.mem_req, bus.mem_addr);
    end
    do_branch(32'h0);
    n_cmp++;
    if (bus.if_flag !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL branch_to_0: flag=%b req=%b, want 0 0", bus.if_flag, bus.mem_req);
    end
    tick();
    n_cmp++;
    if (bus.if_flag !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_inst !== 32'h00000013 || bus.mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL hit_after_branch: flag=%b pc=%h inst=%h req=%b, want 1 0 00000013 0",
               bus.if_flag, bus.if_pc, bus.if_inst, bus.mem_req);
    end
  endtask

  task automatic test_branch_abort();
    bit ok;
    do_branch(32'h40);
    wait_state(3'd3, 100, ok);
    bus.mem_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL abort_reach_b2: state=%0d, want 3", bus.dbg_state);
    end
    do_branch(32'h100);
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.if_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_drop: req=%b flag=%b, want 0 0", bus.mem_req, bus.if_flag);
    end
    tick();
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL abort_refill: req=%b addr=%h, want 1 00000100", bus.mem_req, bus.mem_addr);
    end
    wait_pres(100, ok);
    do_branch(32'h40);
    tick();
    n_cmp++;
    if (!ok || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40) begin
      n_bad++;
      $display("FAIL abort_no_write: ok=%b req=%b addr=%h, want 1 1 00000040", ok, bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] held_pc, held_inst;
    wait_pres(100, ok);
    bus.stall = 6'b000001;
    held_pc   = bus.if_pc;
    held_inst = bus.if_inst;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (!ok || bus.if_flag !== 1'b1 || bus.if_pc !== held_pc || bus.if_inst !== held_inst ||
          bus.mem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold%0d: flag=%b pc=%h inst=%h req=%b, want 1 %h %h 0",
                 i, bus.if_flag, bus.if_pc, bus.if_inst, bus.mem_req, held_pc, held_inst);
      end
    end
    bus.stall = '0;
    wait_pres(100, ok);
    n_cmp++;
    if (!ok || bus.if_pc !== held_pc + 32'd4) begin
      n_bad++;
      $display("FAIL stall_release: ok=%b pc=%h, want 1 %h", ok, bus.if_pc, held_pc + 32'd4);
    end
  endtask

  task automatic test_alias();
    bit ok;
    do_branch(32'h0);
    tick();
    n_cmp++;
    if (bus.if_flag !== 1'b1 || bus.mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL alias_warm_hit: flag=%b req=%b, want 1 0", bus.if_flag, bus.mem_req);
    end
    do_branch(32'h200);
    tick();
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin
      n_bad++;
      $display("FAIL alias_miss_200: req=%b addr=%h, want 1 00000200", bus.mem_req, bus.mem_addr);
    end
    wait_pres(100, ok);
    bus.stall = 6'b000001;
    do_branch(32'h0);
    bus.stall = '0;
    tick();
    n_cmp++;
    if (!ok || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL alias_refetch_0: ok=%b req=%b addr=%h, want 1 1 00000000", ok, bus.mem_req, bus.mem_addr);
    end
    wait_pres(100, ok);
    n_cmp++;
    if (!ok || bus.if_inst !== 32'h00000013) begin
      n_bad++;
      $display("FAIL alias_word: ok=%b inst=%h, want 1 00000013", ok, bus.if_inst);
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    do_branch(32'h300);
    guard = 0;
    while (model_pc != 32'h320 && guard < 400) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (guard >= 400) begin
      n_bad++;
      $display("FAIL b2b_warm: model_pc=%h, want 00000320", model_pc);
    end
    do_branch(32'h300);
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (bus.if_flag !== 1'b1 || bus.if_pc !== 32'h300 + 32'(4 * i) || bus.mem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_hit%0d: flag=%b pc=%h req=%b, want 1 %h 0",
                 i, bus.if_flag, bus.if_pc, bus.mem_req, 32'h300 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    bit ok;
    do_branch(32'h800);
    wait_state(3'd3, 100, ok);
    bus.mem_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (!ok || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.if_flag !== 1'b0 ||
        bus.if_pc !== 32'h0 || bus.if_inst !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset: ok=%b req=%b addr=%h flag=%b pc=%h inst=%h, want 1 and all 0",
               ok, bus.mem_req, bus.mem_addr, bus.if_flag, bus.if_pc, bus.if_inst);
    end
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_refetch: req=%b addr=%h, want 1 00000000", bus.mem_req, bus.mem_addr);
    end
    wait_pres(100, ok);
    n_cmp++;
    if (!ok || bus.if_pc !== 32'h0 || bus.if_inst !== 32'h00000013) begin
      n_bad++;
      $display("FAIL reset_refetch_word: ok=%b pc=%h inst=%h, want 1 0 00000013", ok, bus.if_pc, bus.if_inst);
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    resp_pct = 60;
    spur_en  = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      bus.stall = {5'($urandom), ($urandom_range(0, 99) < 25)};
      if ($urandom_range(0, 99) < 4) begin
        if ($urandom_range(0, 7) == 0) tgt = 32'hFFFFFFF8;
        else tgt = 32'($urandom_range(0, 255)) << 2;
        bus.branch_flag   = 1'b1;
        bus.branch_target = tgt;
      end
      tick();
    end
    bus.stall = '0;
    spur_en   = 1'b0;
  endtask

  initial begin
    mem_a[32'h0] = 8'h13;
    mem_a[32'h1] = 8'h00;
    mem_a[32'h2] = 8'h00;
    mem_a[32'h3] = 8'h00;
    test_reset();
    test_first_fill();
    test_branch_abort();
    test_stall();
    test_alias();
    test_back_to_back();
    test_reset_mid_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
